// File: rtl/latency_data_mem.sv
// Single-port data memory with req/ready/done handshake, independent read and
// write latencies, byte enables and an out-of-range error flag.
module latency_data_mem #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W    = DATA_W / 8;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("latency_data_mem: RD_LAT must be >= 1");
    end
    if (WR_LAT < 1) begin : g_bad_wr_lat
        $error("latency_data_mem: WR_LAT must be >= 1");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("latency_data_mem: DATA_W must be a multiple of 8");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]     mem [0:DEPTH-1];
    logic [CNT_W-1:0]      cnt, cnt_next, lat_sel;
    logic                  op_we;
    logic [ADDR_W-1:0]     op_addr;
    logic [BE_W-1:0]       op_be;
    logic [DATA_W-1:0]     op_wdata;
    logic                  accept, complete, oor;
    logic [DEPTH_LOG2-1:0] idx;

    assign accept   = req & ready;
    assign complete = (cnt == CNT_W'(1));
    assign lat_sel  = we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
    assign idx      = op_addr[DEPTH_LOG2-1:0];

    if (ADDR_W > DEPTH_LOG2) begin : g_range
        assign oor = |op_addr[ADDR_W-1:DEPTH_LOG2];
    end else begin : g_no_range
        assign oor = 1'b0;
    end

    // cnt==1 marks the completion edge; an L=1 op can complete while the next is accepted
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (accept) begin
            cnt_next = lat_sel;
        end else if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
        end
        case (state)
            IDLE:    if (accept && (lat_sel > CNT_W'(1))) state_next = BUSY;
            BUSY:    if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= (state_next == IDLE);
            done  <= complete;
            err   <= complete & oor;
            if (complete && !op_we) begin
                rdata <= oor ? '0 : mem[idx];
            end
            if (accept) begin
                op_we    <= we;
                op_addr  <= addr;
                op_be    <= be;
                op_wdata <= wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && complete && op_we && !oor) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (op_be[i]) begin
                    mem[idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_latency_data_mem.sv
// Directed bench for latency_data_mem: three instances cover the default
// latencies, a long write latency with reset abort, and single-cycle streaming.
module tb_latency_data_mem;

    logic clock;

    logic        reset_a, req_a, we_a, ready_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;

    logic        reset_b, req_b, we_b, ready_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;

    logic        reset_c, req_c, we_c, ready_c, done_c, err_c;
    logic [31:0] addr_c, wdata_c, rdata_c;
    logic [3:0]  be_c;

    int tests = 0;
    int fails = 0;

    latency_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .RD_LAT(2), .WR_LAT(1)) dut_a (
        .clock(clock), .reset(reset_a), .req(req_a), .we(we_a), .addr(addr_a), .be(be_a),
        .wdata(wdata_a), .ready(ready_a), .done(done_a), .err(err_a), .rdata(rdata_a));

    latency_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .RD_LAT(2), .WR_LAT(3)) dut_b (
        .clock(clock), .reset(reset_b), .req(req_b), .we(we_b), .addr(addr_b), .be(be_b),
        .wdata(wdata_b), .ready(ready_b), .done(done_b), .err(err_b), .rdata(rdata_b));

    latency_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .RD_LAT(1), .WR_LAT(1)) dut_c (
        .clock(clock), .reset(reset_c), .req(req_c), .we(we_c), .addr(addr_c), .be(be_c),
        .wdata(wdata_c), .ready(ready_c), .done(done_c), .err(err_c), .rdata(rdata_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op on instance A, confirm done stays low for lat cycles, then pulses
    task automatic run_a(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input int lat);
        req_a = 1'b1; we_a = w; addr_a = a; be_a = b; wdata_a = d;
        tick();
        req_a = 1'b0; we_a = ~w; addr_a = ~a; be_a = 4'hF; wdata_a = ~d;
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".wait_done"}, 64'(done_a), 64'd0);
            chk({tag, ".wait_ready"}, 64'(ready_a), 64'(lat == 1));
            tick();
        end
        chk({tag, ".done"}, 64'(done_a), 64'd1);
        chk({tag, ".ready"}, 64'(ready_a), 64'd1);
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        req_a = 0; we_a = 0; addr_a = '0; be_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; be_b = '0; wdata_b = '0;
        req_c = 0; we_c = 0; addr_c = '0; be_c = '0; wdata_c = '0;
        tick();
        tick();
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        chk("rst.ready", 64'(ready_a), 64'd1);
        chk("rst.done", 64'(done_a), 64'd0);
        chk("rst.err", 64'(err_a), 64'd0);
        chk("rst.rdata", 64'(rdata_a), 64'd0);
        chk("rst_c.ready", 64'(ready_c), 64'd1);

        // Full write then read, default latencies
        run_a("t1_wr", 1'b1, 32'd5, 4'hF, 32'hDEADBEEF, 1);
        chk("t1_wr.err", 64'(err_a), 64'd0);
        run_a("t1_rd", 1'b0, 32'd5, 4'h0, 32'h0, 2);
        chk("t1_rd.rdata", 64'(rdata_a), 64'hDEADBEEF);
        chk("t1_rd.err", 64'(err_a), 64'd0);
        tick();
        chk("t1_hold.done", 64'(done_a), 64'd0);
        chk("t1_hold.rdata", 64'(rdata_a), 64'hDEADBEEF);

        // Byte-enable merge, then be=0 write leaves word unchanged
        run_a("t2_wr_full", 1'b1, 32'd7, 4'hF, 32'hAABBCCDD, 1);
        run_a("t2_wr_part", 1'b1, 32'd7, 4'b0101, 32'h11223344, 1);
        run_a("t2_rd", 1'b0, 32'd7, 4'h0, 32'h0, 2);
        chk("t2_rd.rdata", 64'(rdata_a), 64'hAA22CC44);
        run_a("t2_wr_be0", 1'b1, 32'd7, 4'h0, 32'h00000000, 1);
        chk("t2_wr_be0.err", 64'(err_a), 64'd0);
        run_a("t2_rd2", 1'b0, 32'd7, 4'h0, 32'h0, 2);
        chk("t2_rd2.rdata", 64'(rdata_a), 64'hAA22CC44);

        // Out-of-range access: error flagged, write suppressed, read returns zero
        run_a("t3_wr0", 1'b1, 32'd0, 4'hF, 32'h12345678, 1);
        run_a("t3_wr9", 1'b1, 32'd9, 4'hF, 32'h55AA55AA, 1);
        run_a("t3_rd_oor", 1'b0, 32'h0000_0400, 4'h0, 32'h0, 2);
        chk("t3_rd_oor.err", 64'(err_a), 64'd1);
        chk("t3_rd_oor.rdata", 64'(rdata_a), 64'd0);
        tick();
        chk("t3_idle.err", 64'(err_a), 64'd0);
        chk("t3_idle.rdata", 64'(rdata_a), 64'd0);
        run_a("t3_wr_oor", 1'b1, 32'h0000_0400, 4'hF, 32'hFFFFFFFF, 1);
        chk("t3_wr_oor.err", 64'(err_a), 64'd1);
        run_a("t3_rd0", 1'b0, 32'd0, 4'h0, 32'h0, 2);
        chk("t3_rd0.rdata", 64'(rdata_a), 64'h12345678);
        chk("t3_rd0.err", 64'(err_a), 64'd0);

        // req held through BUSY with changing inputs
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd5;
        tick();
        chk("t4_k.ready", 64'(ready_a), 64'd0);
        we_a = 1'b1; addr_a = 32'd9; wdata_a = 32'hBAD0BAD0; be_a = 4'hF;
        tick();
        chk("t4_k1.ready", 64'(ready_a), 64'd0);
        chk("t4_k1.done", 64'(done_a), 64'd0);
        we_a = 1'b0; addr_a = 32'd7;
        tick();
        chk("t4_first.done", 64'(done_a), 64'd1);
        chk("t4_first.rdata", 64'(rdata_a), 64'hDEADBEEF);
        chk("t4_first.ready", 64'(ready_a), 64'd1);
        tick();
        req_a = 1'b0;
        chk("t4_second_acc.ready", 64'(ready_a), 64'd0);
        chk("t4_second_acc.done", 64'(done_a), 64'd0);
        tick();
        chk("t4_second_wait.done", 64'(done_a), 64'd0);
        tick();
        chk("t4_second.done", 64'(done_a), 64'd1);
        chk("t4_second.rdata", 64'(rdata_a), 64'hAA22CC44);
        run_a("t4_rd9", 1'b0, 32'd9, 4'h0, 32'h0, 2);
        chk("t4_rd9.rdata", 64'(rdata_a), 64'h55AA55AA);

        // Instance B: WR_LAT=3, reset aborts an in-flight write
        req_b = 1'b1; we_b = 1'b1; addr_b = 32'd3; be_b = 4'hF; wdata_b = 32'hCAFEF00D;
        tick();
        req_b = 1'b0;
        tick();
        tick();
        chk("t5_wr.early_done", 64'(done_b), 64'd0);
        tick();
        chk("t5_wr.done", 64'(done_b), 64'd1);
        req_b = 1'b1; we_b = 1'b0;
        tick();
        req_b = 1'b0;
        tick();
        tick();
        chk("t5_rd.done", 64'(done_b), 64'd1);
        chk("t5_rd.rdata", 64'(rdata_b), 64'hCAFEF00D);
        req_b = 1'b1; we_b = 1'b1; wdata_b = 32'h0BADF00D;
        tick();
        req_b = 1'b0;
        chk("t5_acc.ready", 64'(ready_b), 64'd0);
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        chk("t5_rst.ready", 64'(ready_b), 64'd1);
        chk("t5_rst.done", 64'(done_b), 64'd0);
        chk("t5_rst.rdata", 64'(rdata_b), 64'd0);
        chk("t5_rst.err", 64'(err_b), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_after.done", 64'(done_b), 64'd0);
        end
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'd3;
        tick();
        req_b = 1'b0;
        tick();
        tick();
        chk("t5_rd2.done", 64'(done_b), 64'd1);
        chk("t5_rd2.rdata", 64'(rdata_b), 64'hCAFEF00D);

        // Instance C: single-cycle latencies, write/read alternating every cycle
        req_c = 1'b1; we_c = 1'b1; addr_c = 32'd0; be_c = 4'hF; wdata_c = 32'hC0DE0000;
        tick();
        for (int i = 0; i < 16; i++) begin
            we_c = 1'b0; addr_c = 32'(i);
            chk("t6_acc.ready", 64'(ready_c), 64'd1);
            tick();
            chk("t6_wr.done", 64'(done_c), 64'd1);
            chk("t6_wr.ready", 64'(ready_c), 64'd1);
            if (i < 15) begin
                we_c = 1'b1; addr_c = 32'(i + 1); wdata_c = 32'hC0DE0000 + 32'(i + 1) * 32'h111;
            end else begin
                req_c = 1'b0;
            end
            tick();
            chk("t6_rd.done", 64'(done_c), 64'd1);
            chk("t6_rd.ready", 64'(ready_c), 64'd1);
            chk("t6_rd.rdata", 64'(rdata_c), 64'(32'hC0DE0000 + 32'(i) * 32'h111));
        end
        tick();
        chk("t6_end.done", 64'(done_c), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
